bin_to_bcd: RTL and testbench
=============================

// Module: bin_to_bcd
// PURPOSE
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   Sits directly upstream of the 4-digit seven-segment display driver.
//   Converts an unsigned binary count into packed BCD, one nibble per digit,
//   which the display consumes as its 16-bit value input.
//   Out-of-range inputs produce all-0xF nibbles, shown as dashes.
// PARAMETERS
//   IN_WIDTH  14  width of binary input; legal range 4..16
//   DIGITS    4   BCD digits produced; output width is 4*DIGITS
// PORTS
//   clk    in   1           system clock; all state updates on posedge
//   reset  in   1           asynchronous, active-high; clears all state
//   start  in   1           request conversion of bin; sampled on posedge
//   bin    in   IN_WIDTH    unsigned binary value; sampled only when start is accepted
//   busy   out  1           high while a conversion is in progress
//   done   out  1           one-cycle pulse when bcd/ovf update
//   bcd    out  4*DIGITS    packed BCD result; nibble 0 = ones digit; held between conversions
//   ovf    out  1           high when the last accepted bin exceeded 10**DIGITS-1
// BEHAVIOUR
//   Reset values:
//     - busy=0, done=0, bcd=0, ovf=0, FSM=IDLE
//     - Async assert aborts any conversion immediately; no partial result is ever driven.
//   FSM states: IDLE, SHIFT.
//     IDLE:
//       - start=1 at edge E accepts the request: latch bin into the shift register,
//         clear the BCD accumulator, compute the ovf flag (bin > 10**DIGITS-1).
//       - Then busy=1, shift counter=0, go to SHIFT.
//     SHIFT:
//       - Each edge: every BCD digit >= 5 gets +3; then the {accumulator, shift reg}
//         pair shifts left by 1. The add-3 corrections are combinational, applied
//         before the shift in the same edge.
//       - After IN_WIDTH shifts (edges E+1 .. E+IN_WIDTH), the accumulator holds
//         the result.
//       - At edge E+IN_WIDTH+1: load bcd (accumulator, or all 4'hF if ovf),
//         drive ovf, pulse done=1 for exactly one cycle, set busy=0, go to IDLE.
//   Latency: done is visible IN_WIDTH+1 cycles after the accepting edge
//     (15 cycles at defaults).
//   Throughput: start is accepted in the same cycle done is high. Back-to-back
//     conversions run every IN_WIDTH+1 cycles.
//   Ignored inputs:
//     - start while busy=1 is ignored; no queueing.
//     - bin changes after acceptance have no effect.
//   Output stability: bcd and ovf change only on the done edge or on reset.
//     They are glitch-free registered outputs, safe to feed the display directly.
//   Width rules:
//     - Accumulator is 4*DIGITS bits; bits shifted out of its MSB are discarded.
//       This is only reachable on overflow, where the result is replaced anyway.
//     - Shift counter is ceil(log2(IN_WIDTH+1)) bits.
//   Boundary cases:
//     - bin=0 gives bcd=0.
//     - bin=10**DIGITS-1 gives all-9 digits with ovf=0.
//     - bin=10**DIGITS gives bcd=all-F with ovf=1.
//     - If IN_WIDTH < ceil(log2(10**DIGITS)), ovf is constant 0.
// STRUCTURE
//   Shared include display_defs.vh:
//     - FSM state encodings (IDLE=1'b0, SHIFT=1'b1)
//     - BCD_DASH = 4'hF
//     - DISP_DIGITS = 4
//   Sub-module bcd_add3: combinational 4-bit cell, out = (in >= 5) ? in+3 : in.
//     Instantiated DIGITS times via generate.
//   Top level holds the FSM, shift counter, shift register, accumulator and
//   output registers.
// TESTING
//   1. bin=1234, pulse start -> done exactly 15 cycles later; bcd=16'h1234, ovf=0.
//   2. bin=0 then bin=9999 -> bcd=16'h0000, then bcd=16'h9999; ovf=0 both times.
//   3. bin=10000 -> bcd=16'hFFFF, ovf=1. A following bin=42 -> bcd=16'h0042, ovf=0.
//   4. start=1 again at cycle 5 of a 1234 conversion with bin=777
//      -> ignored; result 16'h1234 at the original cycle.
//   5. Assert reset at cycle 7 of a conversion -> busy=0, done=0, bcd=0 immediately;
//      no done pulse follows.
//   6. Hold start=1 continuously with bin=0..20 incrementing on each accept
//      -> done every 15 cycles; bcd follows BCD of each accepted value.

Source files
------------

// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter feeding the
// 4-digit seven-segment display driver.
//   state_t     : FSM state encoding (IDLE=0, SHIFT=1)
//   BCD_DASH    : nibble value the display renders as a dash
//   DISP_DIGITS : number of digits on the display
package bin_to_bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] BCD_DASH    = 4'hF;
  localparam int         DISP_DIGITS = 4;

endpackage

// File: rtl/bcd_add3.sv
// Combinational add-3 correction cell for one BCD digit.
// A digit of 5 or more would become >= 10 after the next left shift.
// Adding 3 first makes that shift carry correctly into the next digit.
//   digit    : current 4-bit BCD digit
//   adjusted : digit + 3 when digit >= 5, otherwise digit unchanged
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// Produces packed BCD for the seven-segment display driver. Out-of-range
// values are shown as all-dash digits.
//   clk   : system clock
//   reset : asynchronous active-high reset, clears all state
//   start : request a conversion of bin
//   bin   : unsigned binary input, latched when start is accepted
//   busy  : high while a conversion is running
//   done  : one-cycle pulse when bcd/ovf update
//   bcd   : packed BCD result (nibble 0 = ones), held between conversions
//   ovf   : last accepted bin exceeded 10**DIGITS-1
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int IN_WIDTH = 14,
  parameter int DIGITS   = DISP_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int          ACC_W   = 4 * DIGITS;
  localparam int          CNT_W   = $clog2(IN_WIDTH + 1);
  localparam logic [63:0] BCD_MAX = 64'(10 ** DIGITS) - 64'd1;

  state_t              state_reg, state_next;
  logic [IN_WIDTH-1:0] sh_reg, sh_next;
  logic [ACC_W-1:0]    acc_reg, acc_next;
  logic [ACC_W-1:0]    acc_adj;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                ovf_pend_reg, ovf_pend_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic [ACC_W-1:0]    bcd_reg, bcd_next;
  logic                ovf_reg, ovf_next;
  logic                accept;

  // Per-digit add-3 corrections, applied before the shift in the same edge.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .digit    (acc_reg[4*gi +: 4]),
      .adjusted (acc_adj[4*gi +: 4])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      sh_reg       <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      ovf_pend_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      bcd_reg      <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sh_reg       <= sh_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      ovf_pend_reg <= ovf_pend_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      bcd_reg      <= bcd_next;
      ovf_reg      <= ovf_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    sh_next       = sh_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    ovf_pend_next = ovf_pend_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    bcd_next      = bcd_reg;
    ovf_next      = ovf_reg;
    accept        = 1'b0;

    case (state_reg)
      IDLE: begin
        accept = start;
      end
      SHIFT: begin
        if (cnt_reg == CNT_W'(IN_WIDTH)) begin
          // Finishing edge: publish the result. A new request is taken on
          // this same edge so back-to-back conversions run every IN_WIDTH+1
          // cycles.
          done_next  = 1'b1;
          bcd_next   = ovf_pend_reg ? {DIGITS{BCD_DASH}} : acc_reg;
          ovf_next   = ovf_pend_reg;
          busy_next  = 1'b0;
          state_next = IDLE;
          accept     = start;
        end else begin
          // Bits leaving the accumulator MSB only occur on overflow.
          acc_next = {acc_adj[ACC_W-2:0], sh_reg[IN_WIDTH-1]};
          sh_next  = {sh_reg[IN_WIDTH-2:0], 1'b0};
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (accept) begin
      sh_next       = bin;
      acc_next      = '0;
      ovf_pend_next = (64'(bin) > BCD_MAX);
      cnt_next      = '0;
      busy_next     = 1'b1;
      state_next    = SHIFT;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign bcd  = bcd_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_bin_to_bcd.sv
module tb_bin_to_bcd;

  localparam int IN_WIDTH = 14;
  localparam int DIGITS   = 4;
  localparam int LAT      = IN_WIDTH + 1;

  logic                clk   = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic [IN_WIDTH-1:0] bin   = '0;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                ovf;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  bin_to_bcd #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Posedge count; read only on negedges.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Small reference for values below 100.
  function automatic logic [15:0] small_bcd(input int v);
    return 16'(((v / 10) << 4) | (v % 10));
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 bcd=%h at cycle %0d, expected no done", bcd, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("done: bcd=%h ovf=%b cycle=%0d (expected bcd=%h ovf=%b cycle=%0d)",
                 bcd, ovf, cyc, e.bcd, e.ovf, e.due);
        check("bcd", 32'(bcd), 32'(e.bcd));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("idle_reached", 32'((q.size() != 0) || busy), 32'd0);
  endtask

  task automatic issue(input int v, input logic [15:0] exp_bcd, input logic exp_ovf);
    @(negedge clk);
    bin   = IN_WIDTH'(v);
    start = 1'b1;
    q.push_back('{exp_bcd, exp_ovf, cyc + LAT + 1});
    $display("issue: bin=%0d expect bcd=%h ovf=%b", v, exp_bcd, exp_ovf);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    wait_idle();
  endtask

  initial begin
    // Reset state
    #1 reset = 1'b1;
    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd",  32'(bcd),  32'd0);
    check("reset_ovf",  32'(ovf),  32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: basic conversion and latency
    issue(1234, 16'h1234, 1'b0);
    // 2: boundaries
    issue(0,    16'h0000, 1'b0);
    issue(9999, 16'h9999, 1'b0);
    // 3: overflow then recovery
    issue(10000, 16'hFFFF, 1'b1);
    issue(42,    16'h0042, 1'b0);

    // 4: start while busy is ignored, bin change has no effect
    @(negedge clk);
    bin   = IN_WIDTH'(1234);
    start = 1'b1;
    q.push_back('{16'h1234, 1'b0, cyc + LAT + 1});
    $display("issue: bin=1234 with ignored restart bin=777");
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bin   = IN_WIDTH'(777);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bin = '0;
    check("busy_ignored_start", 32'(busy), 32'd1);
    wait_idle();

    // 5: asynchronous reset mid-conversion
    @(negedge clk);
    bin   = IN_WIDTH'(1234);
    start = 1'b1;
    $display("issue: bin=1234 then reset at cycle 7");
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    q.delete();
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd",  32'(bcd),  32'd0);
    check("abort_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    check("post_abort_busy", 32'(busy), 32'd0);
    check("post_abort_bcd",  32'(bcd),  32'd0);

    // 6: back-to-back with start held high
    for (int v = 0; v <= 20; v++) begin
      @(negedge clk);
      bin   = IN_WIDTH'(v);
      start = 1'b1;
      q.push_back('{small_bcd(v), 1'b0, cyc + LAT + 1});
      $display("issue: bin=%0d back-to-back expect bcd=%h", v, small_bcd(v));
      @(posedge clk);
      repeat (LAT - 1) @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("final_bcd", 32'(bcd), 32'h0020);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
